// File: rtl/up_down_counter_ms.sv
// Multi-mode up/down counter: wrap, saturate, ping-pong, one-shot.
// Optional: define PINGPONG_MODE_EN for a real ping-pong mode 10.
module up_down_counter_ms #(
   parameter int OUT_WIDTH  = 8,
   parameter int MIN_COUNT  = 0,
   parameter int MAX_COUNT  = 99,
   parameter int STEP_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  up_down,
   input  logic [STEP_WIDTH-1:0] step,
   input  logic [1:0]            mode,
   input  logic                  load,
   input  logic [OUT_WIDTH-1:0]  load_value,
   output logic [OUT_WIDTH-1:0]  count,
   output logic                  dir,
   output logic                  tc,
   output logic                  done,
   output logic                  at_max,
   output logic                  at_min
);

   localparam int SW = OUT_WIDTH + STEP_WIDTH + 1;
   localparam logic [SW-1:0] MIN_X = SW'(MIN_COUNT);
   localparam logic [SW-1:0] MAX_X = SW'(MAX_COUNT);
   localparam logic [SW-1:0] RANGE_X = SW'(MAX_COUNT - MIN_COUNT + 1);
   localparam logic [OUT_WIDTH-1:0] MIN_C = OUT_WIDTH'(MIN_COUNT);
   localparam logic [OUT_WIDTH-1:0] MAX_C = OUT_WIDTH'(MAX_COUNT);

   logic [SW-1:0] cnt_x;
   logic [SW-1:0] stp_x;
   logic [SW-1:0] s_x;
   logic [SW-1:0] up_sum;
   logic [SW-1:0] dn_lim;
   logic          s_zero;
   logic          up_over;
   logic          up_hit;
   logic          dn_under;
   logic          dn_hit;
   logic [OUT_WIDTH-1:0] up_step;
   logic [OUT_WIDTH-1:0] dn_step;
   logic [OUT_WIDTH-1:0] up_wrap;
   logic [OUT_WIDTH-1:0] dn_wrap;
   logic [OUT_WIDTH-1:0] ld_clamp;
   logic [OUT_WIDTH-1:0] cnt_nx;
   logic          tc_nx;
   logic          done_nx;
   logic          dir_nx;
   logic          pp_sel;

   assign at_max = (count == MAX_C);
   assign at_min = (count == MIN_C);

   assign cnt_x  = SW'(count);
   assign stp_x  = SW'(step);
   assign s_x    = (stp_x > RANGE_X) ? RANGE_X : stp_x;
   assign s_zero = (s_x == '0);
   assign up_sum = cnt_x + s_x;
   assign dn_lim = MIN_X + s_x;

   assign up_over  = (up_sum > MAX_X);
   assign up_hit   = (up_sum >= MAX_X);
   assign dn_under = (cnt_x < dn_lim);
   assign dn_hit   = (cnt_x <= dn_lim);

   // Wrapped results fold the overshoot back by one full range.
   assign up_step = OUT_WIDTH'(up_sum);
   assign dn_step = OUT_WIDTH'(cnt_x - s_x);
   assign up_wrap = OUT_WIDTH'(up_sum - RANGE_X);
   assign dn_wrap = OUT_WIDTH'(cnt_x + RANGE_X - s_x);

   assign ld_clamp = (load_value > MAX_C)  ? MAX_C :
                     (load_value <= MIN_C) ? MIN_C : load_value;

`ifdef PINGPONG_MODE_EN
   assign pp_sel = (mode == 2'b10);
`else
   assign pp_sel = 1'b0;
`endif

   // Next-state of a tick, by boundary mode.
   always_comb begin
      cnt_nx  = count;
      tc_nx   = 1'b0;
      done_nx = done;
      dir_nx  = up_down;
      case (mode)
         2'b01, 2'b11: begin
            if (!s_zero && !(mode[1] && done)) begin
               if (up_down) begin
                  cnt_nx  = up_hit ? MAX_C : up_step;
                  tc_nx   = up_hit && !at_max;
                  done_nx = done | (mode[1] & up_hit);
               end else begin
                  cnt_nx  = dn_hit ? MIN_C : dn_step;
                  tc_nx   = dn_hit && !at_min;
                  done_nx = done | (mode[1] & dn_hit);
               end
            end
         end
`ifdef PINGPONG_MODE_EN
         2'b10: begin
            dir_nx = dir;
            if (!s_zero) begin
               if (dir) begin
                  if (up_hit) begin
                     cnt_nx = MAX_C;
                     dir_nx = 1'b0;
                     tc_nx  = 1'b1;
                  end else begin
                     cnt_nx = up_step;
                  end
               end else begin
                  if (dn_hit) begin
                     cnt_nx = MIN_C;
                     dir_nx = 1'b1;
                     tc_nx  = 1'b1;
                  end else begin
                     cnt_nx = dn_step;
                  end
               end
            end
         end
`endif
         default: begin
            if (!s_zero) begin
               if (up_down) begin
                  cnt_nx = up_over ? up_wrap : up_step;
                  tc_nx  = up_over;
               end else begin
                  cnt_nx = dn_under ? dn_wrap : dn_step;
                  tc_nx  = dn_under;
               end
            end
         end
      endcase
   end

   // Registered state with reset > load > tick priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= MIN_C;
         dir   <= 1'b1;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else if (load) begin
         count <= ld_clamp;
         dir   <= up_down;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else if (tick) begin
         count <= cnt_nx;
         dir   <= dir_nx;
         tc    <= tc_nx;
         done  <= done_nx;
      end else begin
         tc    <= 1'b0;
         dir   <= pp_sel ? dir : up_down;
      end
   end

endmodule

// File: tb/tb_up_down_counter_ms.sv
// Scoreboard bench for up_down_counter_ms (default and wide-step instances).
module tb_up_down_counter_ms;

`ifdef PINGPONG_MODE_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       tick;
   logic       up_down;
   logic [3:0] step;
   logic [7:0] step8;
   logic [1:0] mode;
   logic       load;
   logic [7:0] load_value;
   logic [7:0] count;
   logic       dir;
   logic       tc;
   logic       done;
   logic       at_max;
   logic       at_min;
   logic [7:0] count8;
   logic       dir8;
   logic       tc8;
   logic       done8;
   logic       at_max8;
   logic       at_min8;

   int checks;
   int failures;

   typedef struct {
      string      tag;
      logic [7:0] cnt;
      logic       tc;
      logic       done;
   } exp_t;

   exp_t sb[$];

   up_down_counter_ms dut (
      .clk(clk), .reset(reset), .tick(tick), .up_down(up_down),
      .step(step), .mode(mode), .load(load), .load_value(load_value),
      .count(count), .dir(dir), .tc(tc), .done(done),
      .at_max(at_max), .at_min(at_min)
   );

   up_down_counter_ms #(.STEP_WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .tick(tick), .up_down(up_down),
      .step(step8), .mode(mode), .load(load), .load_value(load_value),
      .count(count8), .dir(dir8), .tc(tc8), .done(done8),
      .at_max(at_max8), .at_min(at_min8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input bit r, input bit ld,
                      input logic [7:0] lv, input bit tk, input bit ud,
                      input logic [3:0] st, input logic [1:0] md,
                      input logic [7:0] ec, input bit etc, input bit edn);
      exp_t e;
      @(negedge clk);
      reset      = r;
      load       = ld;
      load_value = lv;
      tick       = tk;
      up_down    = ud;
      step       = st;
      step8      = {4'b0, st};
      mode       = md;
      e.tag  = tag;
      e.cnt  = ec;
      e.tc   = etc;
      e.done = edn;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".count"}, int'(count), int'(e.cnt));
      check({e.tag, ".tc"}, int'(tc), int'(e.tc));
      check({e.tag, ".done"}, int'(done), int'(e.done));
   endtask

   initial begin
      bit ud_pp;
      checks = 0;
      failures = 0;
      reset = 1'b1; load = 1'b0; load_value = 8'd0; tick = 1'b0;
      up_down = 1'b1; step = 4'd0; step8 = 8'd0; mode = 2'b00;

      cyc("rst", 1, 0, 0, 0, 1, 0, 0, 8'd0, 0, 0);
      check("rst.dir", int'(dir), 1);
      check("rst.at_min", int'(at_min), 1);
      check("rst.at_max", int'(at_max), 0);

      cyc("wr.ld", 0, 1, 98, 0, 1, 3, 2'b00, 8'd98, 0, 0);
      cyc("wr.up", 0, 0, 0, 1, 1, 3, 2'b00, 8'd1, 1, 0);
      cyc("wr.idle", 0, 0, 0, 0, 1, 3, 2'b00, 8'd1, 0, 0);
      cyc("wr.dn", 0, 0, 0, 1, 0, 2, 2'b00, 8'd99, 1, 0);
      check("wr.at_max", int'(at_max), 1);
      cyc("wr.idle2", 0, 0, 0, 0, 0, 2, 2'b00, 8'd99, 0, 0);

      cyc("sat.ld", 0, 1, 5, 0, 0, 4, 2'b01, 8'd5, 0, 0);
      check("sat.dir", int'(dir), 0);
      cyc("sat.t1", 0, 0, 0, 1, 0, 4, 2'b01, 8'd1, 0, 0);
      cyc("sat.t2", 0, 0, 0, 1, 0, 4, 2'b01, 8'd0, 1, 0);
      cyc("sat.t3", 0, 0, 0, 1, 0, 4, 2'b01, 8'd0, 0, 0);
      check("sat.at_min", int'(at_min), 1);

      ud_pp = PP ? 1'b0 : 1'b1;
      cyc("pp.ld", 0, 1, 97, 0, 1, 2, 2'b10, 8'd97, 0, 0);
      if (PP) begin
         cyc("pp.t1", 0, 0, 0, 1, ud_pp, 2, 2'b10, 8'd99, 1, 0);
         check("pp.dir", int'(dir), 0);
         cyc("pp.t2", 0, 0, 0, 1, ud_pp, 2, 2'b10, 8'd97, 0, 0);
         cyc("pp.t3", 0, 0, 0, 1, ud_pp, 2, 2'b10, 8'd95, 0, 0);
      end else begin
         cyc("m2.t1", 0, 0, 0, 1, ud_pp, 2, 2'b10, 8'd99, 0, 0);
         cyc("m2.t2", 0, 0, 0, 1, ud_pp, 2, 2'b10, 8'd1, 1, 0);
         cyc("m2.t3", 0, 0, 0, 1, ud_pp, 2, 2'b10, 8'd3, 0, 0);
         check("m2.dir", int'(dir), 1);
      end

      cyc("os.ld", 0, 1, 10, 0, 1, 5, 2'b11, 8'd10, 0, 0);
      for (int k = 1; k <= 18; k++) begin
         int v;
         v = 10 + 5 * k;
         if (v > 99) v = 99;
         cyc("os.run", 0, 0, 0, 1, 1, 5, 2'b11, 8'(v), k == 18, k == 18);
      end
      for (int k = 0; k < 3; k++)
         cyc("os.hold", 0, 0, 0, 1, 1, 5, 2'b11, 8'd99, 0, 1);
      cyc("os.clr", 0, 1, 0, 0, 1, 5, 2'b11, 8'd0, 0, 0);

      cyc("pri.pre", 0, 0, 0, 1, 1, 7, 2'b00, 8'd7, 0, 0);
      cyc("pri.rst", 1, 1, 200, 1, 0, 7, 2'b00, 8'd0, 0, 0);
      check("pri.dir", int'(dir), 1);
      cyc("pri.ld", 0, 1, 200, 1, 1, 3, 2'b00, 8'd99, 0, 0);
      check("pri.at_max", int'(at_max), 1);

      cyc("s0.wr", 0, 0, 0, 1, 1, 0, 2'b00, 8'd99, 0, 0);
      cyc("s0.sat", 0, 0, 0, 1, 0, 0, 2'b01, 8'd99, 0, 0);

      cyc("big.ld", 0, 1, 0, 0, 1, 0, 2'b00, 8'd0, 0, 0);
      check("big.ld8", int'(count8), 0);
      @(negedge clk);
      load  = 1'b0;
      tick  = 1'b1;
      step  = 4'd15;
      step8 = 8'd150;
      @(posedge clk);
      #1;
      check("big.count8", int'(count8), 0);
      check("big.tc8", int'(tc8), 1);
      check("big.count4", int'(count), 15);
      check("big.tc4", int'(tc), 0);

      @(negedge clk);
      tick = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/up_down_counter_ms.md
# up_down_counter_ms

Parametrised multi-mode up/down counter. It succeeds the single-mode modulo counter and adds:
- programmable lower and upper bounds;
- a variable step size;
- synchronous load;
- four boundary modes: wrap, saturate, ping-pong and one-shot.

It is the general-purpose counting element for display, timer and scan logic, and is advanced by an external `tick` strobe from a prescaler.

## Interface
Parameters:
- `OUT_WIDTH`, 8: width of `count`.
- `MIN_COUNT`, 0: lower bound, inclusive.
- `MAX_COUNT`, 99: upper bound, inclusive. Requires MIN_COUNT < MAX_COUNT < 2^OUT_WIDTH.
- `STEP_WIDTH`, 4: width of `step`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  count enable; one step per cycle while high.
- `up_down`  in  1  1 = count up, 0 = count down. In ping-pong mode it is sampled only on load.
- `step`  in  STEP_WIDTH  step magnitude; 0 means hold.
- `mode`  in  2  00 wrap, 01 saturate, 10 ping-pong, 11 one-shot.
- `load`  in  1  synchronous load of `load_value`.
- `load_value`  in  OUT_WIDTH  value to load; clamped into [MIN_COUNT, MAX_COUNT].
- `count`  out  OUT_WIDTH  current count (registered).
- `dir`  out  1  effective direction used by the next step (registered).
- `tc`  out  1  terminal-count pulse (registered).
- `done`  out  1  one-shot finished (sticky, registered).
- `at_max`  out  1  combinational, `count == MAX_COUNT`.
- `at_min`  out  1  combinational, `count == MIN_COUNT`.

## Operation
- Priority per edge: reset > load > tick. `mode` and `step` are sampled on the tick edge.
- Reset values: `count` = MIN_COUNT, `dir` = 1, `tc` = 0, `done` = 0.
- Load:
  - `count` takes the clamped `load_value`; `dir` takes `up_down`.
  - `done` and `tc` clear.
  - A tick in the same cycle is ignored.
- Step arithmetic:
  - RANGE = MAX_COUNT − MIN_COUNT + 1.
  - Effective step s = min(step, RANGE).
  - Sums are computed at OUT_WIDTH+STEP_WIDTH+1 bits, so there is no intermediate overflow.
  - s = 0: `count` holds and `tc` = 0.
- Direction: in modes 00, 01 and 11, `dir` follows `up_down` every cycle. In mode 10, `dir` is internal state.
- Wrap (00):
  - Up: if count+s > MAX_COUNT, next = MIN_COUNT + (count+s − MAX_COUNT − 1).
  - Down: if count−s < MIN_COUNT, next = MAX_COUNT − (MIN_COUNT − (count−s) − 1).
  - Crossing a bound sets `tc`.
- Saturate (01):
  - The result is clamped to the bound.
  - `tc` is set on the step that first reaches the bound.
  - Further ticks at the bound hold `count` with `tc` = 0.
- Ping-pong (10, only with the macro defined):
  - Reaching or crossing a bound clamps `count` to that bound, inverts `dir` and sets `tc`.
  - The next tick moves away from the bound.
- One-shot (11):
  - Counts like saturate. Reaching the bound sets `tc` and `done`.
  - While `done` = 1, ticks are ignored.
  - Only load or reset clears `done`.
- `tc` is high for exactly one cycle after each boundary event and never on consecutive cycles without a new event.
- Mode change mid-count: takes effect on the next tick and does not disturb `count`.
- A `done` already set stays set when leaving mode 11.

## Timing
- Latency is 1 cycle: `count`, `dir`, `tc` and `done` reflect a tick/load/reset edge at edge N immediately after edge N.
- `at_max` and `at_min` follow `count` combinationally, with no added delay.
- A back-to-back tick every cycle is supported; throughput is one step per clock.
- Reset asserted mid-count overrides load and tick on that edge.

## Configuration
- `PINGPONG_MODE_EN` defined: mode 10 implements ping-pong with a registered internal `dir`.
- Not defined:
  - Mode 10 behaves exactly as wrap (00).
  - `dir` always follows `up_down`.
  - The ping-pong logic is absent.

## Test plan
All scenarios use default parameters (MIN 0, MAX 99).
- Wrap up: load 98, step 3, mode 00, up, one tick → `count` = 1, `tc` pulses 1 cycle. Then a down tick with step 2 → `count` = 99, `tc` pulses.
- Saturate: load 5, step 4, down, mode 01, two ticks → 1, then 0 with `tc`. A third tick → holds at 0, `tc` = 0, `at_min` = 1.
- Ping-pong (macro on): load 97, up, step 2, mode 10, three ticks → 99 (`tc` = 1, `dir` = 0), then 97, then 95.
- One-shot: load 10, up, step 5, mode 11, tick until 99 → `done` = 1, `tc` pulses once. Further ticks leave 99. Load 0 → `done` = 0.
- Priority and clamp: reset, load (load_value 200) and tick in the same cycle → `count` = 0. Next cycle load 200 with tick → `count` = 99, no step applied.
- Step 0 and step > RANGE: step 0 with tick → `count` unchanged. Mode 00, load 0, up, with STEP_WIDTH widened to 8 and step 150 → s = 100, `count` = 0, `tc` = 1.
